// File: rtl/brightness_fader.sv
// -----------------------------------------------------------------------------
// brightness_fader
//
// Slew-rate limiter and on/off control sitting between the encoder-driven
// brightness register and pwm_gen. value_o walks toward the goal one LSB per
// step tick, so encoder jumps and on/off transitions fade smoothly instead of
// snapping. A debounced push button toggles the light on and off.
//
//   goal = enable_o ? target_i : 0
//
// Ports
//   clk_i     in   1           system clock
//   rst_n_i   in   1           asynchronous, active-low reset
//   target_i  in   VALUE_SIZE  requested brightness (synchronous to clk_i)
//   btn_i     in   1           raw push button, asynchronous, active-high
//   value_o   out  VALUE_SIZE  current duty value for pwm_gen
//   enable_o  out  1           light on (1) / off (0)
//   busy_o    out  1           1 while value_o != goal (ramp in progress)
//
// Handshake: none. target_i is sampled every cycle as a level, and the
// outputs are plain registered levels with no valid/ready qualification.
//
// The ramp FSM state is held in the internal signal 'state' (IDLE/UP/DOWN),
// so checkers can bind to it directly.
// -----------------------------------------------------------------------------
module brightness_fader #(
  parameter int VALUE_SIZE     = 8,
  parameter int CLOCK_FREQ_MHZ = 100,
  parameter int STEP_PERIOD_US = 1000,
  parameter int DEBOUNCE_US    = 10000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [VALUE_SIZE-1:0] target_i,
  input  logic                  btn_i,
  output logic [VALUE_SIZE-1:0] value_o,
  output logic                  enable_o,
  output logic                  busy_o
);

  localparam int STEP_CYCLES = CLOCK_FREQ_MHZ * STEP_PERIOD_US;
  localparam int DEB_CYCLES  = CLOCK_FREQ_MHZ * DEBOUNCE_US;

  // Keep counters at least one bit wide for degenerate 1-cycle settings.
  localparam int PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(STEP_CYCLES - 1);
  localparam logic [DEB_W-1:0]      DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [VALUE_SIZE-1:0] VALUE_MAX = '1;
  localparam logic [VALUE_SIZE-1:0] VALUE_ONE = VALUE_SIZE'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic                  btn_meta;
  logic                  btn_s;
  logic                  btn_db;
  logic                  btn_db_q;
  logic                  btn_rise;
  logic [DEB_W-1:0]      deb_cnt;

  logic [PRE_W-1:0]      pre_cnt;
  logic                  step_tick;

  logic                  enable;
  logic [VALUE_SIZE-1:0] value;
  logic [VALUE_SIZE-1:0] value_next;
  logic [VALUE_SIZE-1:0] goal;
  logic                  busy;

  // ---------------------------------------------------------------------------
  // Button path: 2-FF synchronizer, debounce, rising-edge toggle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      deb_cnt  <= '0;
      enable   <= 1'b1;
    end else begin
      btn_meta <= btn_i;
      btn_s    <= btn_meta;
      btn_db_q <= btn_db;
      // The counter only runs while the synchronized input disagrees with the
      // debounced level; any bounce back to agreement restarts the wait.
      if (btn_s != btn_db) begin
        if (deb_cnt == DEB_LAST) begin
          btn_db  <= btn_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
      if (btn_rise) begin
        enable <= ~enable;
      end
    end
  end

  assign btn_rise = btn_db & ~btn_db_q;

  // ---------------------------------------------------------------------------
  // Free-running step prescaler; ticks regardless of ramp state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  assign step_tick = (pre_cnt == PRE_LAST);

  assign goal = enable ? target_i : '0;

  // ---------------------------------------------------------------------------
  // Ramp FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      value <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      value <= value_next;
      busy  <= (state_next != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Ramp FSM: next state. Compared against the value being written this cycle
  // so the FSM (and busy) settle on the same edge value reaches the goal; this
  // also keeps a tick on every cycle from stepping past the goal.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = IDLE;
    if (value_next < goal) begin
      state_next = UP;
    end else if (value_next > goal) begin
      state_next = DOWN;
    end
  end

  // ---------------------------------------------------------------------------
  // Ramp FSM: outputs. The step direction follows the registered state, so a
  // goal change landing on a tick is honoured only from the next tick on.
  // The floor/ceiling guards make wrap-around impossible.
  // ---------------------------------------------------------------------------
  always_comb begin
    value_next = value;
    if (step_tick) begin
      case (state)
        UP: begin
          if (value != VALUE_MAX) begin
            value_next = value + VALUE_ONE;
          end
        end
        DOWN: begin
          if (value != '0) begin
            value_next = value - VALUE_ONE;
          end
        end
        default: begin
          value_next = value;
        end
      endcase
    end
  end

  assign value_o  = value;
  assign enable_o = enable;
  assign busy_o   = busy;

endmodule
